decode_pipe: RTL and testbench
==============================

Name: decode_pipe

Overview:
Registered, parametrised successor to the pd2 combinational decode stage. It sits between fetch and the register-file/execute stages and accepts one instruction per cycle over a valid/ready handshake. It decodes all RV32I fields and generates the sign-extended immediate for I/S/B/U/J formats in place of the old dummy zero. Decoded outputs come from an output register backed by a one-entry skid buffer, so ready is registered and back-pressure never drops an instruction; flush and illegal-opcode flagging are also supported.

Parameters:
AWIDTH, 32, PC width.
DWIDTH, 32, instruction/immediate width; only 32 is supported (elaboration error otherwise).
ZERO_UNUSED, 1, 1 = fields not used by the format are driven 0; 0 = raw bit-slices are always driven.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid_i  in  1  upstream instruction valid
ready_o  out  1  stage can accept (registered: ~skid_valid, forced 0 while rst=1)
insn_i  in  DWIDTH  instruction
pc_i  in  AWIDTH  instruction PC
flush_i  in  1  discard all held and incoming instructions
valid_o  out  1  decoded bundle valid
ready_i  in  1  downstream accepts the bundle
pc_o  out  AWIDTH  PC of the bundle
insn_o  out  DWIDTH  raw instruction
opcode_o  out  7  insn[6:0]
rd_o, rs1_o, rs2_o  out  5 each  register indices
funct3_o  out  3  funct3
funct7_o  out  7  funct7
shamt_o  out  5  shift amount
imm_o  out  DWIDTH  sign-extended immediate
illegal_o  out  1  opcode not in the RV32I base set

Behaviour:
- Reset (rst=1 at a clk edge): valid_o=0, skid cleared, all bundle outputs 0, illegal_o=0; ready_o=0 during reset and 1 on the first cycle after.
- Accept = valid_i & ready_o. Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
- Output register loads when (!valid_o | ready_i). It takes the skid entry if one is held, otherwise the incoming instruction.
- If accept occurs while valid_o=1 and ready_i=0, the instruction goes to the skid; ready_o drops the next cycle.
- Skid full and ready_i=1: skid moves to output. A simultaneous input cannot happen because ready_o=0.
- Outputs are held stable while valid_o=1 and ready_i=0.
- flush_i=1 at an edge clears valid_o and the skid and discards any same-cycle input; ready_o=1 next cycle. flush has priority over everything except rst.
- Field rules (ZERO_UNUSED=1):
  - R (0110011): rd, rs1, rs2, funct3, funct7.
  - I-ALU (0010011): rd, rs1, funct3. When funct3 is 001 or 101, also shamt=insn[24:20] and funct7.
  - LOAD (0000011) and JALR (1100111): rd, rs1, funct3.
  - S (0100011) and B (1100011): rs1, rs2, funct3.
  - LUI, AUIPC, JAL: rd only.
  - All unused fields are 0.
- Immediates:
  - I: sext(insn[31:20]).
  - S: sext({insn[31:25], insn[11:7]}).
  - B: sext({insn[31], insn[7], insn[30:25], insn[11:8], 1'b0}).
  - U: {insn[31:12], 12'b0}.
  - J: sext({insn[31], insn[19:12], insn[20], insn[30:21], 1'b0}).
  - R type: imm_o=0.
- FENCE (0001111) and SYSTEM (1110011) are legal with all fields 0 and imm 0. Any other opcode gives illegal_o=1, decoded fields/imm 0; pc_o, insn_o and opcode_o are still passed through.
- All decode is computed on the input side and registered; outputs have no combinational path from insn_i.

Test Plan:
1. ADDI x5,x6,-1 (0xFFF30293), pc 0x4, ready_i=1 -> next cycle valid_o=1, rd=5, rs1=6, rs2=0, funct3=000, imm_o=0xFFFFFFFF, illegal_o=0.
2. SW x7,8(x8) (0x00742423), then BEQ x1,x2,-4 (0xFE208EE3) -> imm_o 0x00000008, then 0xFFFFFFFC; rd=0, rs2=7, then rs2=2.
3. LUI x10,0x12345 (0x12345537), then JAL x1,8 (0x008000EF) -> imm_o 0x12345000, then 0x00000008; only rd nonzero (10, then 1).
4. Back-pressure: ready_i=0, issue 3 back-to-back instructions -> first held on outputs, second in skid, ready_o=0 from cycle 3, third stalls upstream. Then ready_i=1 -> all three delivered in order, none lost or duplicated.
5. Flush with skid full and valid_i=1 -> next cycle valid_o=0, ready_o=1, the discarded instructions never appear. Assert rst mid-stream -> all outputs 0 after that edge.
6. Illegal insn 0x0000007F -> illegal_o=1, imm_o=0, opcode_o=7'h7F. SRAI x8,x9,7 (0x4074D413) -> shamt=7, funct7=0x20.

Source files
------------

// File: rtl/decode_pipe.sv
// decode_pipe: registered RV32I decode stage with valid/ready handshake.
// Decode is computed from the incoming instruction, then captured either in
// the output register or, under back-pressure, in a one-entry skid buffer so
// that the upstream ready can be a registered signal without losing data.
module decode_pipe #(
    parameter int AWIDTH      = 32,
    parameter int DWIDTH      = 32,
    parameter int ZERO_UNUSED = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DWIDTH-1:0] insn_i,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [6:0]        opcode_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output logic [4:0]        shamt_o,
    output logic [DWIDTH-1:0] imm_o,
    output logic              illegal_o
);

    // The immediate formats below are hard-wired to 32-bit instructions.
    if (DWIDTH != 32) begin : g_bad_dwidth
        $error("decode_pipe: DWIDTH must be 32");
    end

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // When set, every field is the raw bit-slice regardless of format.
    localparam bit KEEP_RAW = (ZERO_UNUSED == 0);

    typedef struct packed {
        logic [AWIDTH-1:0] pc;
        logic [DWIDTH-1:0] insn;
        logic [6:0]        opcode;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [4:0]        shamt;
        logic [DWIDTH-1:0] imm;
        logic              illegal;
    } bundle_t;

    bundle_t w_dec;
    logic    w_use_rd;
    logic    w_use_rs1;
    logic    w_use_rs2;
    logic    w_use_f3;
    logic    w_use_f7;
    logic    w_use_shamt;

    // Input-side decode: field usage per format and the sign-extended immediate.
    always_comb begin
        w_dec         = '0;
        w_use_rd      = 1'b0;
        w_use_rs1     = 1'b0;
        w_use_rs2     = 1'b0;
        w_use_f3      = 1'b0;
        w_use_f7      = 1'b0;
        w_use_shamt   = 1'b0;
        w_dec.pc      = pc_i;
        w_dec.insn    = insn_i;
        w_dec.opcode  = insn_i[6:0];
        case (insn_i[6:0])
            OP_R: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_use_f3  = 1'b1;
                w_use_f7  = 1'b1;
            end
            OP_IMM: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_f3  = 1'b1;
                w_dec.imm = {{20{insn_i[31]}}, insn_i[31:20]};
                // Shifts carry shamt and the arithmetic/logical funct7 bit.
                if (insn_i[14:12] == 3'b001 || insn_i[14:12] == 3'b101) begin
                    w_use_shamt = 1'b1;
                    w_use_f7    = 1'b1;
                end
            end
            OP_LOAD, OP_JALR: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_f3  = 1'b1;
                w_dec.imm = {{20{insn_i[31]}}, insn_i[31:20]};
            end
            OP_STORE: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_use_f3  = 1'b1;
                w_dec.imm = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
            end
            OP_BRANCH: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_use_f3  = 1'b1;
                w_dec.imm = {{19{insn_i[31]}}, insn_i[31], insn_i[7],
                             insn_i[30:25], insn_i[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                w_use_rd  = 1'b1;
                w_dec.imm = {insn_i[31:12], 12'b0};
            end
            OP_JAL: begin
                w_use_rd  = 1'b1;
                w_dec.imm = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12],
                             insn_i[20], insn_i[30:21], 1'b0};
            end
            OP_FENCE, OP_SYSTEM: begin
                // Legal, but nothing is decoded for these.
            end
            default: begin
                w_dec.illegal = 1'b1;
            end
        endcase
        w_dec.rd     = (w_use_rd    || KEEP_RAW) ? insn_i[11:7]  : 5'd0;
        w_dec.rs1    = (w_use_rs1   || KEEP_RAW) ? insn_i[19:15] : 5'd0;
        w_dec.rs2    = (w_use_rs2   || KEEP_RAW) ? insn_i[24:20] : 5'd0;
        w_dec.funct3 = (w_use_f3    || KEEP_RAW) ? insn_i[14:12] : 3'd0;
        w_dec.funct7 = (w_use_f7    || KEEP_RAW) ? insn_i[31:25] : 7'd0;
        w_dec.shamt  = (w_use_shamt || KEEP_RAW) ? insn_i[24:20] : 5'd0;
    end

    bundle_t r_out;
    bundle_t r_skid;
    logic    r_out_valid;
    logic    r_skid_valid;
    logic    w_accept;
    logic    w_load_out;

    // Ready depends only on skid state, so it carries no path from ready_i.
    assign ready_o    = ~r_skid_valid & ~rst;
    assign w_accept   = valid_i & ready_o;
    assign w_load_out = ~r_out_valid | ready_i;

    // Output register plus skid: skid drains first, new data parks in the
    // skid only when the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush_i) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_load_out) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_accept;
                if (w_accept) begin
                    r_out <= w_dec;
                end
            end
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end

    assign valid_o   = r_out_valid;
    assign pc_o      = r_out.pc;
    assign insn_o    = r_out.insn;
    assign opcode_o  = r_out.opcode;
    assign rd_o      = r_out.rd;
    assign rs1_o     = r_out.rs1;
    assign rs2_o     = r_out.rs2;
    assign funct3_o  = r_out.funct3;
    assign funct7_o  = r_out.funct7;
    assign shamt_o   = r_out.shamt;
    assign imm_o     = r_out.imm;
    assign illegal_o = r_out.illegal;

endmodule

// File: tb/tb_decode_pipe.sv
// Directed testbench for decode_pipe with hand-computed expected values.
module tb_decode_pipe;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] insn_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] pc_o;
    logic [31:0] insn_o;
    logic [6:0]  opcode_o;
    logic [4:0]  rd_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [2:0]  funct3_o;
    logic [6:0]  funct7_o;
    logic [4:0]  shamt_o;
    logic [31:0] imm_o;
    logic        illegal_o;

    int n_pass;
    int n_total;

    decode_pipe #(.AWIDTH(32), .DWIDTH(32), .ZERO_UNUSED(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .insn_i    (insn_i),
        .pc_i      (pc_i),
        .flush_i   (flush_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .pc_o      (pc_o),
        .insn_o    (insn_o),
        .opcode_o  (opcode_o),
        .rd_o      (rd_o),
        .rs1_o     (rs1_o),
        .rs2_o     (rs2_o),
        .funct3_o  (funct3_o),
        .funct7_o  (funct7_o),
        .shamt_o   (shamt_o),
        .imm_o     (imm_o),
        .illegal_o (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run is a fixed sequence, so this only fires on a hang.
    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single edge, then drop valid.
    task automatic send(input logic [31:0] insn, input logic [31:0] pc);
        valid_i = 1'b1;
        insn_i  = insn;
        pc_i    = pc;
        $display("txn pc=0x%08h insn=0x%08h ready_o=%0b ready_i=%0b", pc, insn, ready_o, ready_i);
        tick();
        valid_i = 1'b0;
    endtask

    task automatic chk_fields(input string tag, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] sh, input logic [31:0] imm, input logic ill);
        chk({tag, ".valid"},   valid_o,   1'b1);
        chk({tag, ".rd"},      rd_o,      rd);
        chk({tag, ".rs1"},     rs1_o,     rs1);
        chk({tag, ".rs2"},     rs2_o,     rs2);
        chk({tag, ".funct3"},  funct3_o,  f3);
        chk({tag, ".funct7"},  funct7_o,  f7);
        chk({tag, ".shamt"},   shamt_o,   sh);
        chk({tag, ".imm"},     imm_o,     imm);
        chk({tag, ".illegal"}, illegal_o, ill);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        valid_i = 1'b0;
        insn_i  = '0;
        pc_i    = '0;
        flush_i = 1'b0;
        ready_i = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst.valid",   valid_o,   1'b0);
        chk("rst.ready",   ready_o,   1'b0);
        chk("rst.pc",      pc_o,      32'h0);
        chk("rst.imm",     imm_o,     32'h0);
        chk("rst.illegal", illegal_o, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst.ready_after", ready_o, 1'b1);

        // 1: ADDI x5,x6,-1
        send(32'hFFF30293, 32'h4);
        chk_fields("addi", 5'd5, 5'd6, 5'd0, 3'b000, 7'd0, 5'd0, 32'hFFFFFFFF, 1'b0);
        chk("addi.pc", pc_o, 32'h4);

        // 2: SW x7,8(x8) then BEQ x1,x2,-4
        send(32'h00742423, 32'h8);
        chk_fields("sw", 5'd0, 5'd8, 5'd7, 3'b010, 7'd0, 5'd0, 32'h00000008, 1'b0);
        send(32'hFE208EE3, 32'hC);
        chk_fields("beq", 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 5'd0, 32'hFFFFFFFC, 1'b0);

        // 3: LUI x10,0x12345 then JAL x1,8
        send(32'h12345537, 32'h10);
        chk_fields("lui", 5'd10, 5'd0, 5'd0, 3'b000, 7'd0, 5'd0, 32'h12345000, 1'b0);
        send(32'h008000EF, 32'h14);
        chk_fields("jal", 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 5'd0, 32'h00000008, 1'b0);

        // 6: illegal opcode, then SRAI x8,x9,7
        send(32'h0000007F, 32'h18);
        chk_fields("ill", 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 5'd0, 32'h0, 1'b1);
        chk("ill.opcode", opcode_o, 7'h7F);
        chk("ill.insn",   insn_o,   32'h0000007F);
        send(32'h4074D413, 32'h1C);
        chk_fields("srai", 5'd8, 5'd9, 5'd0, 3'b101, 7'h20, 5'd7, 32'h00000407, 1'b0);

        // Drain
        tick();
        chk("drain.valid", valid_o, 1'b0);

        // 4: back-pressure with three back-to-back instructions
        ready_i = 1'b0;
        send(32'hFFF30293, 32'h100);        // A -> output
        chk("bp.a_out",  pc_o,    32'h100);
        chk("bp.ready1", ready_o, 1'b1);
        send(32'h00742423, 32'h104);        // B -> skid
        chk("bp.a_hold", pc_o,    32'h100);
        chk("bp.ready2", ready_o, 1'b0);
        valid_i = 1'b1;                     // C stalled upstream
        insn_i  = 32'h12345537;
        pc_i    = 32'h108;
        $display("txn pc=0x%08h insn=0x%08h ready_o=%0b ready_i=%0b", pc_i, insn_i, ready_o, ready_i);
        tick();
        chk("bp.a_hold2",   pc_o,    32'h100);
        chk("bp.a_imm",     imm_o,   32'hFFFFFFFF);
        chk("bp.ready3",    ready_o, 1'b0);
        ready_i = 1'b1;
        tick();                             // skid B to output; C not accepted
        chk("bp.b_valid", valid_o, 1'b1);
        chk("bp.b_out",   pc_o,    32'h104);
        chk("bp.b_imm",   imm_o,   32'h00000008);
        chk("bp.ready4",  ready_o, 1'b1);
        tick();                             // C accepted
        valid_i = 1'b0;
        chk("bp.c_out", pc_o,  32'h108);
        chk("bp.c_imm", imm_o, 32'h12345000);
        tick();
        chk("bp.empty", valid_o, 1'b0);

        // 5: flush with skid full and a same-cycle input
        ready_i = 1'b0;
        send(32'hFFF30293, 32'h200);
        send(32'h00742423, 32'h204);
        chk("fl.ready_pre", ready_o, 1'b0);
        flush_i = 1'b1;
        valid_i = 1'b1;
        insn_i  = 32'h008000EF;
        pc_i    = 32'h208;
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk("fl.valid", valid_o, 1'b0);
        chk("fl.ready", ready_o, 1'b1);
        ready_i = 1'b1;
        tick();
        chk("fl.gone1", valid_o, 1'b0);
        tick();
        chk("fl.gone2", valid_o, 1'b0);

        // Reset mid-stream
        send(32'h4074D413, 32'h300);
        chk("mr.valid_pre", valid_o, 1'b1);
        rst = 1'b1;
        tick();
        chk("mr.valid",  valid_o, 1'b0);
        chk("mr.pc",     pc_o,    32'h0);
        chk("mr.insn",   insn_o,  32'h0);
        chk("mr.imm",    imm_o,   32'h0);
        chk("mr.rd",     rd_o,    5'd0);
        chk("mr.ready",  ready_o, 1'b0);
        rst = 1'b0;
        #1;
        chk("mr.ready_after", ready_o, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
